// File: rtl/m_ext_pkg.sv
// Shared definitions for the RV32M execution unit: widths, funct3 codes,
// FSM encoding and the architectural special-case constants.
package m_ext_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

    // Two's complement negate when en is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/m_ext_unit_mul.sv
// Combinational signed 33x33 multiplier; the caller chooses sign/zero
// extension of each operand so one array serves all four multiply ops.
module mul_33x33 (
    input  logic [32:0] a_i,
    input  logic [32:0] b_i,
    output logic [65:0] p_o
);
    logic signed [65:0] a_ext_s;
    logic signed [65:0] b_ext_s;

    assign a_ext_s = 66'($signed(a_i));
    assign b_ext_s = 66'($signed(b_i));
    assign p_o     = a_ext_s * b_ext_s;

endmodule

// File: rtl/m_ext_unit.sv
// RV32M EX-stage unit: two-cycle multiply through mul_33x33 and a 32-step
// restoring divider, returning one registered result with a done pulse.
module m_ext_unit
    import m_ext_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_e          state_q, state_d;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [XLEN:0]   rem_q;
    logic [4:0]      cnt_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [XLEN-1:0] result_q;

    logic            is_div_s, is_signed_s, div_zero_s, div_ovf_s, special_s, accept_s;
    logic [XLEN-1:0] special_res_s;
    logic [32:0]     mul_a_s, mul_b_s;
    logic [65:0]     prod_s;
    logic [XLEN-1:0] mul_res_s;
    logic [XLEN:0]   rem_shift_s, rem_next_s;
    logic            q_bit_s;
    logic [XLEN-1:0] fix_res_s;
    logic            unused_bits_s;

    assign is_div_s    = funct3[2];
    assign is_signed_s = ~funct3[0];
    assign div_zero_s  = (rs2 == 32'd0);
    assign div_ovf_s   = is_signed_s && (rs1 == INT_MIN) && (rs2 == 32'hFFFF_FFFF);
    assign special_s   = is_div_s && (div_zero_s || div_ovf_s);
    assign accept_s    = (state_q == ST_IDLE) && start && !flush;

    // Special-case result is known at accept, so those ops skip the divider.
    always_comb begin
        special_res_s = DIV_BY_ZERO_Q;
        if (div_zero_s) begin
            special_res_s = funct3[1] ? rs1 : DIV_BY_ZERO_Q;
        end else begin
            special_res_s = funct3[1] ? 32'd0 : INT_MIN;
        end
    end

    assign mul_a_s = {((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) ? op_a_q[31] : 1'b0, op_a_q};
    assign mul_b_s = {(f3_q == F3_MULH) ? op_b_q[31] : 1'b0, op_b_q};

    mul_33x33 u_mul (
        .a_i (mul_a_s),
        .b_i (mul_b_s),
        .p_o (prod_s)
    );

    assign mul_res_s = (f3_q == F3_MUL) ? prod_s[31:0] : prod_s[63:32];

    // One restoring step: shift in the next dividend bit, keep the subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q[XLEN-1:0], op_a_q[XLEN-1]};
        if (rem_shift_s >= {1'b0, op_b_q}) begin
            rem_next_s = rem_shift_s - {1'b0, op_b_q};
            q_bit_s    = 1'b1;
        end else begin
            rem_next_s = rem_shift_s;
            q_bit_s    = 1'b0;
        end
    end

    assign fix_res_s = f3_q[1] ? neg_if(rem_q[XLEN-1:0], r_neg_q) : neg_if(op_a_q, q_neg_q);

    assign unused_bits_s = ^{prod_s[65:64], rem_q[XLEN]};

    // Next-state logic; flush overrides everything, including a new start.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (!is_div_s)      state_d = ST_MUL;
                        else if (special_s) state_d = ST_DONE;
                        else                state_d = ST_DIV;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL:  state_d = ST_DONE;
                ST_DIV:  state_d = (cnt_q == 5'(DIV_STEPS - 1)) ? ST_FIX : ST_DIV;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, divider iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q     <= 3'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
            rem_q    <= 33'd0;
            cnt_q    <= 5'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 32'd0;
        end else if (accept_s) begin
            f3_q  <= funct3;
            rem_q <= 33'd0;
            cnt_q <= 5'd0;
            if (is_div_s && is_signed_s) begin
                op_a_q  <= neg_if(rs1, rs1[31]);
                op_b_q  <= neg_if(rs2, rs2[31]);
                q_neg_q <= rs1[31] ^ rs2[31];
                r_neg_q <= rs1[31];
            end else begin
                op_a_q  <= rs1;
                op_b_q  <= rs2;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
            end
            if (special_s) result_q <= special_res_s;
            else           result_q <= result_q;
        end else if (!flush) begin
            case (state_q)
                ST_MUL: result_q <= mul_res_s;
                ST_DIV: begin
                    op_a_q <= {op_a_q[XLEN-2:0], q_bit_s};
                    rem_q  <= rem_next_s;
                    cnt_q  <= cnt_q + 5'd1;
                end
                ST_FIX:  result_q <= fix_res_s;
                default: result_q <= result_q;
            endcase
        end else begin
            result_q <= result_q;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Directed bench for m_ext_unit: table of ops with hand-computed results and
// latencies, plus flush, start-while-busy and mid-divide reset sequences.
module tb_m_ext_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush, busy, done;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, result;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          poke;
    } vec_t;

    vec_t vecs[23];

    m_ext_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one op at the current negedge; poke_k injects a MUL start in cycle T0+poke_k.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int poke_k, output logic [31:0] res, output int lat,
                          output logic busy_ok);
        funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        lat = 0; busy_ok = 1'b1; res = 32'd0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == poke_k) begin
                start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k; res = result;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] res, last_res;
        int          lat, seen_done;
        logic        busy_ok;

        vecs[0]  = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 2, 0};
        vecs[1]  = '{3'b011, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 2, 2};
        vecs[2]  = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 2, 0};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 2, 0};
        vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0};
        vecs[5]  = '{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 0};
        vecs[6]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 2, 0};
        vecs[7]  = '{3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 2, 0};
        vecs[8]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0};
        vecs[9]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0};
        vecs[10] = '{3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1, 0};
        vecs[11] = '{3'b111, 32'd100,       32'd0,         32'd100,       1, 0};
        vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0};
        vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0};
        vecs[14] = '{3'b101, 32'd1000,      32'd7,         32'd142,       34, 0};
        vecs[15] = '{3'b111, 32'd1000,      32'd7,         32'd6,         34, 0};
        vecs[16] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 0};
        vecs[17] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34, 0};
        vecs[18] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0};
        vecs[19] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0};
        vecs[20] = '{3'b100, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, 0};
        vecs[21] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 0};
        vecs[22] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 5};

        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        last_res = 32'd0;
        for (int i = 0; i < 23; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].poke, res, lat, busy_ok);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_held", i), {31'd0, busy_ok}, 32'd1);
            check($sformatf("v%0d_idle_after", i), {30'd0, busy, done}, 32'd0);
            last_res = vecs[i].exp;
        end

        // Flush with a simultaneous start mid-divide: nothing completes, nothing accepted.
        funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        seen_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) begin
                flush = 1'b1; start = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
            end else begin
                start = 1'b0;
            end
            if (done) seen_done++;
        end
        @(negedge clk);
        if (done) seen_done++;
        check("flush_idle", {30'd0, busy, done}, 32'd0);
        check("flush_result_held", result, last_res);
        check("flush_no_done", seen_done, 0);
        flush = 1'b0;
        run_op(3'b000, 32'd3, 32'd4, 0, res, lat, busy_ok);
        check("reissue_mul_result", res, 32'd12);
        check("reissue_mul_latency", lat, 2);

        // Reset in the middle of a divide abandons it silently.
        funct3 = 3'b100; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) rst = 1'b1;
        end
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        check("rst_no_done_after", seen_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/m_ext_unit.md
Name: m_ext_unit

Overview:
- EX-stage RV32M execution unit: accepts decoded M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) with operands from the ID/EX register.
- Drives the 33x33 multiplier, runs an iterative restoring divider, and returns one registered 32-bit result to the EX/MEM result mux.
- Asserts busy so hazard logic stalls IF/ID/EX while an op is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- DIV_STEPS, 32, divider iterations (equals XLEN).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  32  operand A.
- rs2  in  32  operand B.
- flush  in  1  abort (branch/exception flush).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  32  registered result; holds last value until next completion.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; counter and internal registers = 0. Reset mid-operation abandons the op with no done pulse.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept: start=1 in IDLE at edge T0. Latch funct3, rs1, rs2. A start while busy is ignored.
- Flush: in any state, returns to IDLE next edge, no done pulse, result unchanged. Flush has priority over start in the same cycle; nothing is accepted.
- Multiply:
  - IDLE->MUL at T0.
  - In MUL, operands extend to 33 bits: signed for rs1 on MULH/MULHSU, signed for rs2 on MULH only, zero-extended otherwise.
  - Product bits [31:0] for MUL, [63:32] for the others, registered at T0+1.
  - MUL->DONE at T0+1; done high during cycle T0+2 (latency 2).
- Divide, normal path:
  - At T0, latch |rs1| and |rs2| for signed ops (raw for unsigned), record quotient sign = rs1[31]^rs2[31] and remainder sign = rs1[31] (signed ops only). Clear remainder and counter; IDLE->DIV.
  - DIV: one restoring step per cycle, shifting the 33-bit partial remainder, trial subtract, and setting the quotient bit.
  - The counter runs 0..31. When the counter reaches 31, DIV->FIX.
  - FIX: apply sign correction (two's complement) and select quotient (DIV/DIVU) or remainder (REM/REMU). Result registered; FIX->DONE.
  - done high during cycle T0+34.
- Divide special cases, detected at accept, IDLE->DONE directly with result loaded; done during T0+1:
  - rs2==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- DONE: done=1, busy=1 for one cycle, then ->IDLE. A start in the DONE cycle is ignored; back-to-back issue is accepted the following cycle.
- Arithmetic is pure two's complement. The divider remainder is 33 bits internally so the trial subtract never loses a carry.

Decomposition:
- Shared package m_ext_pkg: XLEN; funct3 localparams (F3_MUL..F3_REMU); FSM state encoding (3-bit enum IDLE/MUL/DIV/FIX/DONE); constants DIV_BY_ZERO_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000.
- Sub-module mul_33x33: combinational signed 33x33 -> 66-bit product. Instantiated once; the unit does operand extension and the slice select.
- Divider datapath stays inline in m_ext_unit.

Test Plan:
- Reset then MULH rs1=0xFFFFFFFE (-2), rs2=0x00000003 -> done at T0+2, result=0xFFFFFFFF. The same op with MULHU gives 0x00000002; MUL gives 0xFFFFFFFA.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> busy for cycles T0+1..T0+34, done at T0+34, result=0xFFFFFFFD (-3). REM with the same operands gives 0xFFFFFFFF (-1).
- DIVU rs1=100, rs2=0 -> done at T0+1, result=0xFFFFFFFF. REMU with the same operands gives 100.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done at T0+1, result=0x80000000. REM with the same operands gives 0.
- Start DIVU 1000/7; at cycle T0+10 assert flush together with a new start (MUL 3*4) -> no done, IDLE next cycle, result unchanged. The MUL re-issued the next cycle completes with result 12.
- Assert start while busy mid-DIV, and rst at cycle T0+5 of a divide -> extra start ignored; after rst: busy=0, done=0, result=0, and no done pulse ever appears.
